// File: rtl/kalman_result_tx.sv
// Serialises one Kalman result (X, P) into a host frame:
// SYNC, X bytes MSB-first, P bytes MSB-first, XOR checksum of the X/P bytes.
module kalman_result_tx #(
    parameter int         DATA_W    = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_x,
    input  logic [DATA_W-1:0] res_p,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ack,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic [2:0]        dbg_state
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_XB   = 3'd2,
        ST_PB   = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    state_t            state_q;
    logic [1:0]        idx_q;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] p_q;
    logic [7:0]        csum_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic [7:0]        frame_cnt_q;

    logic       xfer;
    logic       last_idx;
    logic [1:0] idx_d;
    logic [7:0] x_first;
    logic [7:0] p_first;
    logic [7:0] x_next;
    logic [7:0] p_next;

    // Byte i of v counted from the MSB end; out-of-range indices yield zero.
    function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] v, input logic [1:0] i);
        int sh;
        sh = 8 * (NB - 1 - int'(i));
        if (sh < 0) begin
            return 8'h00;
        end
        return 8'(v >> sh);
    endfunction

    assign xfer     = tx_valid_q & tx_ack;
    assign last_idx = (idx_q == 2'(NB - 1));
    assign idx_d    = idx_q + 2'd1;
    assign x_first  = byte_sel(x_q, 2'd0);
    assign p_first  = byte_sel(p_q, 2'd0);
    assign x_next   = byte_sel(x_q, idx_d);
    assign p_next   = byte_sel(p_q, idx_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            x_q         <= '0;
            p_q         <= '0;
            csum_q      <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (res_valid && res_ready) begin
                        x_q        <= res_x;
                        p_q        <= res_p;
                        csum_q     <= 8'h00;
                        tx_data_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (xfer) begin
                        idx_q     <= 2'd0;
                        tx_data_q <= x_first;
                        csum_q    <= csum_q ^ x_first;
                        state_q   <= ST_XB;
                    end
                end
                ST_XB: begin
                    if (xfer) begin
                        if (last_idx) begin
                            idx_q     <= 2'd0;
                            tx_data_q <= p_first;
                            csum_q    <= csum_q ^ p_first;
                            state_q   <= ST_PB;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= x_next;
                            csum_q    <= csum_q ^ x_next;
                        end
                    end
                end
                ST_PB: begin
                    if (xfer) begin
                        if (last_idx) begin
                            // csum_q already folds in every byte presented so far
                            tx_data_q <= csum_q;
                            state_q   <= ST_CSUM;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= p_next;
                            csum_q    <= csum_q ^ p_next;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        tx_valid_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        csum_q      <= 8'h00;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_ready = (state_q == ST_IDLE);
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_kalman_result_tx.sv
// Bench for kalman_result_tx: fixed vectors, hand-built corner sequences and
// random frames checked against a byte-level frame model and expected queue.
module tb_kalman_result_tx;
    localparam int DW        = 16;
    localparam int NB        = DW / 8;
    localparam int FRAME_LEN = 2 * NB + 2;

    // Handshakes: res_valid/res_ready transfer on a rising edge with both high;
    // tx_valid/tx_ack transfer a byte on a rising edge with both high.
    logic          clk = 1'b0;
    logic          rst;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_x;
    logic [DW-1:0] res_p;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ack;
    logic          busy;
    logic [7:0]    frame_cnt;
    logic [2:0]    dbg_state;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cnt_model;
    logic [7:0] last_byte;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] p;
        logic [7:0]    csum;
    } vec_t;
    vec_t tv[6];

    always #5 clk = ~clk;

    kalman_result_tx #(.DATA_W(DW), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_x     (res_x),
        .res_p     (res_p),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ack    (tx_ack),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: sync byte, then X and P high byte first, then XOR of those data bytes.
    task automatic model_frame(input logic [DW-1:0] x, input logic [DW-1:0] p);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = NB - 1; i >= 0; i--) begin
            b = x[8*i +: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        for (int i = NB - 1; i >= 0; i--) begin
            b = p[8*i +: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        res_valid = 1'b0;
        tx_ack    = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        cnt_model = 8'h00;
    endtask

    task automatic start_frame(input logic [DW-1:0] x, input logic [DW-1:0] p);
        int w;
        w = 0;
        while (!res_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_capture", 32'(res_ready), 32'd1);
        res_valid = 1'b1;
        res_x     = x;
        res_p     = p;
        model_frame(x, p);
        @(negedge clk);
        res_valid = 1'b0;
        res_x     = DW'($urandom);
        res_p     = DW'($urandom);
        check("sync_latency", 32'({tx_valid, tx_data}), 32'({1'b1, 8'hA5}));
    endtask

    // Takes n bytes starting at a negedge inside a frame; ends at the negedge after the last transfer.
    task automatic collect(input int n, input int gap_pct);
        int         got;
        int         cyc;
        logic       stalled;
        logic [7:0] held;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = 8'h00;
        while (got < n && cyc < 2000) begin
            check("in_frame_valid", 32'(tx_valid), 32'd1);
            check("in_frame_busy", 32'({busy, res_ready}), 32'({1'b1, 1'b0}));
            if (!tx_valid) break;
            if (stalled) check("hold_data", 32'(tx_data), 32'(held));
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                tx_ack  = 1'b0;
                stalled = 1'b1;
                held    = tx_data;
            end else begin
                tx_ack  = 1'b1;
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual=%0h expected=none", tx_data);
                end else begin
                    check("frame_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                last_byte = tx_data;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ack = 1'b0;
        check("bytes_received", 32'(got), 32'(n));
    endtask

    task automatic frame_done();
        cnt_model = cnt_model + 8'd1;
        check("end_idle", 32'({tx_valid, busy, res_ready}), 32'({1'b0, 1'b0, 1'b1}));
        check("frame_cnt", 32'(frame_cnt), 32'(cnt_model));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{16'h1234, 16'h00FF, 8'hD9};
        tv[1] = '{16'h0000, 16'h0000, 8'h00};
        tv[2] = '{16'hFFFF, 16'hFFFF, 8'h00};
        tv[3] = '{16'h8001, 16'h0102, 8'h82};
        tv[4] = '{16'hDEAD, 16'hBEEF, 8'h22};
        tv[5] = '{16'hFFFF, 16'h1E2D, 8'h33};
        res_x = '0;
        res_p = '0;
        last_byte = 8'h00;

        // Reset state
        do_reset(2);
        check("rst_outputs", 32'({tx_valid, busy, res_ready}), 32'({1'b0, 1'b0, 1'b1}));
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);

        // Ack in idle is ignored
        tx_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ack_ignored", 32'({tx_valid, busy, frame_cnt}), 32'd0);
        end
        tx_ack = 1'b0;

        // Abort after byte 0x12, then a clean frame
        start_frame(16'h1234, 16'h00FF);
        collect(2, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("abort_idle", 32'({tx_valid, busy, res_ready}), 32'({1'b0, 1'b0, 1'b1}));
        check("abort_frame_cnt", 32'(frame_cnt), 32'(cnt_model));
        start_frame(16'h1234, 16'h00FF);
        collect(FRAME_LEN, 0);
        check("abort_next_csum", 32'(last_byte), 32'hD9);
        frame_done();

        // Table of back-to-back frames with ack held high
        for (int i = 0; i < 6; i++) begin
            start_frame(tv[i].x, tv[i].p);
            collect(FRAME_LEN, 0);
            check("table_csum", 32'(last_byte), 32'(tv[i].csum));
            frame_done();
        end

        // Backpressure on 0x34 for 3 cycles
        start_frame(16'h1234, 16'h00FF);
        collect(2, 0);
        repeat (3) begin
            check("stall_hold", 32'({tx_valid, busy, tx_data}), 32'({1'b1, 1'b1, 8'h34}));
            @(negedge clk);
        end
        collect(FRAME_LEN - 2, 0);
        check("stall_csum", 32'(last_byte), 32'hD9);
        frame_done();

        // Result offered mid-frame is held off until idle
        start_frame(16'h1234, 16'h00FF);
        collect(3, 0);
        res_valid = 1'b1;
        res_x     = 16'hFFFF;
        res_p     = 16'h1E2D;
        collect(FRAME_LEN - 3, 0);
        check("refused_csum", 32'(last_byte), 32'hD9);
        frame_done();
        model_frame(16'hFFFF, 16'h1E2D);
        @(negedge clk);
        res_valid = 1'b0;
        res_x     = 16'h0000;
        res_p     = 16'h0000;
        check("held_capture", 32'({tx_valid, tx_data}), 32'({1'b1, 8'hA5}));
        collect(FRAME_LEN, 0);
        check("held_csum", 32'(last_byte), 32'h33);
        frame_done();

        // 256 random frames with random ack gaps wrap the counter
        do_reset(2);
        for (int f = 0; f < 256; f++) begin
            start_frame(DW'($urandom), DW'($urandom));
            collect(FRAME_LEN, 30);
            frame_done();
            repeat ($urandom_range(0, 2)) begin
                tx_ack = 1'($urandom);
                @(negedge clk);
            end
            tx_ack = 1'b0;
        end
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
